mem_access_stage: RTL

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives a request/acknowledge data-memory port. Non-memory operations pass straight through to the MEM/WB boundary in one cycle. Loads and stores are issued as a single outstanding memory transaction, and the upstream pipeline is stalled until that transaction completes or times out. Sits between the EX/MEM register and the writeback stage.

---
 rtl/mem_access_stage_pkg.sv | 11 +
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage.
package mem_access_stage_pkg;

    localparam int ARQ_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage.sv
// Memory stage: ALU passthrough plus one outstanding req/ack data-memory transaction.
import mem_access_stage_pkg::*;

module mem_access_stage #(
    parameter int ARQ     = ARQ_W,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wb_enable_in,
    input  logic           rd_mem_en,
    input  logic           wr_mem_en,
    input  logic           pc_en_in,
    input  logic [ARQ-1:0] src1_in,
    input  logic [ARQ-1:0] srcdest_in,
    input  logic [ARQ-1:0] alu_result_in,
    output logic           mem_req,
    output logic           mem_we,
    output logic [ARQ-1:0] mem_addr,
    output logic [ARQ-1:0] mem_wdata,
    input  logic [ARQ-1:0] mem_rdata,
    input  logic           mem_ack,
    output logic           stall,
    output logic           wb_enable_out,
    output logic           pc_en_out,
    output logic [ARQ-1:0] wb_data_out,
    output logic [ARQ-1:0] srcdest_out,
    output logic           mem_err
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    mem_state_t     state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [ARQ-1:0] addr_q, addr_d;
    logic [ARQ-1:0] wdata_q, wdata_d;
    logic           lat_wb_q, lat_wb_d;
    logic           lat_pc_q, lat_pc_d;
    logic [ARQ-1:0] lat_sd_q, lat_sd_d;
    logic           wb_en_q, wb_en_d;
    logic           pc_en_q, pc_en_d;
    logic [ARQ-1:0] wb_data_q, wb_data_d;
    logic [ARQ-1:0] sd_q, sd_d;
    logic           err_q, err_d;

    logic is_mem, busy, timeout, done;

    assign is_mem  = rd_mem_en | wr_mem_en;
    assign busy    = (state_q == BUSY);
    assign timeout = busy & ~mem_ack & (cnt_q == LAST_CNT);
    assign done    = busy & (mem_ack | timeout);
    assign stall   = (~busy & is_mem) | (busy & ~done);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_wb_d  = lat_wb_q;
        lat_pc_d  = lat_pc_q;
        lat_sd_d  = lat_sd_q;
        wb_en_d   = wb_en_q;
        pc_en_d   = pc_en_q;
        wb_data_d = wb_data_q;
        sd_d      = sd_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (is_mem) begin
                    // A simultaneous read+write request issues only the store.
                    state_d  = BUSY;
                    cnt_d    = '0;
                    req_d    = 1'b1;
                    we_d     = wr_mem_en;
                    addr_d   = alu_result_in;
                    wdata_d  = src1_in;
                    lat_wb_d = wb_enable_in;
                    lat_pc_d = pc_en_in;
                    lat_sd_d = srcdest_in;
                    wb_en_d  = 1'b0;
                    pc_en_d  = 1'b0;
                end else begin
                    wb_en_d   = wb_enable_in;
                    pc_en_d   = pc_en_in;
                    wb_data_d = alu_result_in;
                    sd_d      = srcdest_in;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    wb_en_d   = lat_wb_q;
                    pc_en_d   = lat_pc_q;
                    sd_d      = lat_sd_q;
                    wb_data_d = we_q ? addr_q : (mem_ack ? mem_rdata : '0);
                    if (timeout) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_wb_q  <= 1'b0;
            lat_pc_q  <= 1'b0;
            lat_sd_q  <= '0;
            wb_en_q   <= 1'b0;
            pc_en_q   <= 1'b0;
            wb_data_q <= '0;
            sd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_wb_q  <= lat_wb_d;
            lat_pc_q  <= lat_pc_d;
            lat_sd_q  <= lat_sd_d;
            wb_en_q   <= wb_en_d;
            pc_en_q   <= pc_en_d;
            wb_data_q <= wb_data_d;
            sd_q      <= sd_d;
            err_q     <= err_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign wb_enable_out = wb_en_q;
    assign pc_en_out     = pc_en_q;
    assign wb_data_out   = wb_data_q;
    assign srcdest_out   = sd_q;
    assign mem_err       = err_q;

endmodule
